// File: rtl/addr_decoder_n.sv
// Serial slave-index address decoder: shifts SEL_BITS bits LSB first, then holds a
// one-hot slave select (with split-busy masking) for as long as the bus stays utilised.
module addr_decoder_n #(
    parameter int                  SEL_BITS   = 2,
    parameter int                  N_SLAVES   = 3,
    parameter logic [N_SLAVES-1:0] SPLIT_MASK = 'b001
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                B_UTIL,
    input  logic                A_ADD,
    input  logic                B_BUS_OUT,
    input  logic [N_SLAVES-1:0] B_SBSY,
    output logic [N_SLAVES-1:0] AD_SEL,
    output logic [N_SLAVES-1:0] SPL_SEL,
    output logic                AD_VALID,
    output logic                AD_ERR
);

    if (SEL_BITS < 1 || N_SLAVES > (2 ** SEL_BITS) - 1) begin : g_param_check
        $error("addr_decoder_n: N_SLAVES must fit in 1..2**SEL_BITS-1 and SEL_BITS must be >= 1");
    end

    localparam int                CNT_W   = $clog2(SEL_BITS + 1);
    localparam logic [SEL_BITS:0] MAX_IDX = (SEL_BITS + 1)'(N_SLAVES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [SEL_BITS-1:0] r_idx,   w_idx_nxt;
    logic [CNT_W-1:0]    r_cnt,   w_cnt_nxt;
    logic                w_shift_en;
    logic                w_hold;
    logic                w_idx_oob;
    logic                w_hit;

    assign w_shift_en = B_UTIL & A_ADD;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                w_idx_nxt = '0;
                w_cnt_nxt = '0;
                if (w_shift_en) begin
                    w_idx_nxt[0] = B_BUS_OUT;
                    w_cnt_nxt    = CNT_W'(1);
                    w_state_nxt  = (SEL_BITS == 1) ? HOLD : SHIFT;
                end
            end
            SHIFT: begin
                if (w_shift_en) begin
                    for (int unsigned i = 1; i < SEL_BITS; i++) begin
                        if (r_cnt == CNT_W'(i)) begin
                            w_idx_nxt[i] = B_BUS_OUT;
                        end
                    end
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(SEL_BITS - 1)) begin
                        w_state_nxt = HOLD;
                    end
                end else begin
                    // Either bus released or address phase aborted: drop partial bits.
                    w_state_nxt = IDLE;
                    w_idx_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            end
            HOLD: begin
                if (!B_UTIL) begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_hold    = (r_state == HOLD);
        w_idx_oob = (r_idx == '0) || ({1'b0, r_idx} > MAX_IDX);
        AD_VALID  = w_hold;
        AD_ERR    = w_hold & w_idx_oob;
        AD_SEL    = '0;
        SPL_SEL   = '0;
        w_hit     = 1'b0;
        // Split-busy only gates the select of split-capable slaves; it is a same-cycle path.
        for (int unsigned i = 1; i <= N_SLAVES; i++) begin
            w_hit        = w_hold && (r_idx == SEL_BITS'(i));
            SPL_SEL[i-1] = w_hit & SPLIT_MASK[i-1];
            AD_SEL[i-1]  = w_hit & ~(SPLIT_MASK[i-1] & B_SBSY[i-1]);
        end
    end

endmodule

// File: tb/tb_addr_decoder_n.sv
// Scoreboard bench for addr_decoder_n: default configuration plus a
// SEL_BITS=3 / N_SLAVES=5 / SPLIT_MASK=5'b10100 instance.
module tb_addr_decoder_n;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       a_util = 1'b0, a_add = 1'b0, a_bit = 1'b0;
    logic [2:0] a_sbsy = '0;
    logic [2:0] a_sel, a_spl;
    logic       a_valid, a_err;

    logic       b_util = 1'b0, b_add = 1'b0, b_bit = 1'b0;
    logic [4:0] b_sbsy = '0;
    logic [4:0] b_sel, b_spl;
    logic       b_valid, b_err;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    typedef struct {
        string       tag;
        int unsigned which;
        logic [4:0]  sel;
        logic [4:0]  spl;
        logic        valid;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    addr_decoder_n u_dut_a (
        .CLK       (clk),
        .RST       (rst),
        .B_UTIL    (a_util),
        .A_ADD     (a_add),
        .B_BUS_OUT (a_bit),
        .B_SBSY    (a_sbsy),
        .AD_SEL    (a_sel),
        .SPL_SEL   (a_spl),
        .AD_VALID  (a_valid),
        .AD_ERR    (a_err)
    );

    addr_decoder_n #(
        .SEL_BITS   (3),
        .N_SLAVES   (5),
        .SPLIT_MASK (5'b10100)
    ) u_dut_b (
        .CLK       (clk),
        .RST       (rst),
        .B_UTIL    (b_util),
        .A_ADD     (b_add),
        .B_BUS_OUT (b_bit),
        .B_SBSY    (b_sbsy),
        .AD_SEL    (b_sel),
        .SPL_SEL   (b_spl),
        .AD_VALID  (b_valid),
        .AD_ERR    (b_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic push_exp(input int unsigned which, input string tag,
                            input logic [4:0] sel, input logic [4:0] spl,
                            input logic valid, input logic err);
        exp_t e;
        e.tag   = tag;
        e.which = which;
        e.sel   = sel;
        e.spl   = spl;
        e.valid = valid;
        e.err   = err;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.which == 0) begin
                check_eq({e.tag, ".sel"},   {2'b00, a_sel}, e.sel);
                check_eq({e.tag, ".spl"},   {2'b00, a_spl}, e.spl);
                check_eq({e.tag, ".valid"}, a_valid,        e.valid);
                check_eq({e.tag, ".err"},   a_err,          e.err);
            end else begin
                check_eq({e.tag, ".sel"},   b_sel,   e.sel);
                check_eq({e.tag, ".spl"},   b_spl,   e.spl);
                check_eq({e.tag, ".valid"}, b_valid, e.valid);
                check_eq({e.tag, ".err"},   b_err,   e.err);
            end
        end
    endtask

    // One sampling edge: inputs set on the falling edge, outputs compared 1ns after the rising edge.
    task automatic drive(input int unsigned which, input logic u, input logic ad, input logic bt,
                         input string tag, input logic [4:0] sel, input logic [4:0] spl,
                         input logic valid, input logic err);
        @(negedge clk);
        if (which == 0) begin
            a_util = u; a_add = ad; a_bit = bt;
        end else begin
            b_util = u; b_add = ad; b_bit = bt;
        end
        push_exp(which, tag, sel, spl, valid, err);
        @(posedge clk);
        #1;
        drain();
    endtask

    // Mid-cycle look at combinational outputs after a B_SBSY change.
    task automatic probe(input int unsigned which, input string tag,
                         input logic [4:0] sel, input logic [4:0] spl,
                         input logic valid, input logic err);
        push_exp(which, tag, sel, spl, valid, err);
        #1;
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset overrides an active address phase
        rst = 1'b1;
        drive(0, 1, 1, 1, "rst_a", 5'b0, 5'b0, 0, 0);
        probe(1, "rst_b", 5'b0, 5'b0, 0, 0);
        rst = 1'b0;

        // Address 2 (bits 0,1), held while B_UTIL=1, A_ADD/B_BUS_OUT ignored
        drive(0, 1, 1, 0, "a2_bit0", 5'b0, 5'b0, 0, 0);
        drive(0, 1, 1, 1, "a2_hold", 5'b00010, 5'b0, 1, 0);
        drive(0, 1, 0, 0, "a2_ign1", 5'b00010, 5'b0, 1, 0);
        drive(0, 1, 1, 1, "a2_ign2", 5'b00010, 5'b0, 1, 0);
        drive(0, 0, 0, 0, "a2_drop", 5'b0, 5'b0, 0, 0);

        // Back-to-back: address 1 (split-capable), busy gating same cycle
        drive(0, 1, 1, 1, "a1_bit0", 5'b0, 5'b0, 0, 0);
        drive(0, 1, 1, 0, "a1_hold", 5'b00001, 5'b00001, 1, 0);
        a_sbsy = 3'b001;
        probe(0, "a1_busy", 5'b0, 5'b00001, 1, 0);
        a_sbsy = 3'b000;
        probe(0, "a1_free", 5'b00001, 5'b00001, 1, 0);
        drive(0, 0, 0, 0, "a1_drop", 5'b0, 5'b0, 0, 0);

        // Address 0 is an error
        drive(0, 1, 1, 0, "a0_bit0", 5'b0, 5'b0, 0, 0);
        drive(0, 1, 1, 0, "a0_err", 5'b0, 5'b0, 1, 1);
        drive(0, 0, 0, 0, "a0_drop", 5'b0, 5'b0, 0, 0);

        // Abort after one bit, then full address 3
        drive(0, 1, 1, 1, "ab_bit0", 5'b0, 5'b0, 0, 0);
        drive(0, 1, 0, 0, "ab_abort", 5'b0, 5'b0, 0, 0);
        drive(0, 1, 1, 1, "a3_bit0", 5'b0, 5'b0, 0, 0);
        drive(0, 1, 1, 1, "a3_hold", 5'b00100, 5'b0, 1, 0);
        a_sbsy = 3'b110;
        probe(0, "a3_nonsplit_busy", 5'b00100, 5'b0, 1, 0);
        a_sbsy = 3'b000;

        // Reset during HOLD on slave 3
        rst = 1'b1;
        drive(0, 1, 1, 1, "rst_hold", 5'b0, 5'b0, 0, 0);
        rst = 1'b0;

        // Reset mid-SHIFT discards the partial bit
        drive(0, 1, 1, 1, "rs_bit0", 5'b0, 5'b0, 0, 0);
        rst = 1'b1;
        drive(0, 1, 1, 1, "rs_reset", 5'b0, 5'b0, 0, 0);
        rst = 1'b0;
        drive(0, 1, 1, 0, "rs_new0", 5'b0, 5'b0, 0, 0);
        drive(0, 1, 1, 1, "rs_hold", 5'b00010, 5'b0, 1, 0);
        a_sbsy = 3'b010;
        probe(0, "rs_nonsplit_busy", 5'b00010, 5'b0, 1, 0);
        a_sbsy = 3'b000;
        drive(0, 0, 0, 0, "rs_drop", 5'b0, 5'b0, 0, 0);

        // Wide instance: address 5 (bits 1,0,1) split-capable and busy
        b_sbsy = 5'b10000;
        drive(1, 1, 1, 1, "b5_bit0", 5'b0, 5'b0, 0, 0);
        drive(1, 1, 1, 0, "b5_bit1", 5'b0, 5'b0, 0, 0);
        drive(1, 1, 1, 1, "b5_busy", 5'b0, 5'b10000, 1, 0);
        b_sbsy = 5'b00000;
        probe(1, "b5_free", 5'b10000, 5'b10000, 1, 0);
        drive(1, 0, 0, 0, "b5_drop", 5'b0, 5'b0, 0, 0);

        // Address 7 exceeds N_SLAVES
        drive(1, 1, 1, 1, "b7_bit0", 5'b0, 5'b0, 0, 0);
        drive(1, 1, 1, 1, "b7_bit1", 5'b0, 5'b0, 0, 0);
        drive(1, 1, 1, 1, "b7_err", 5'b0, 5'b0, 1, 1);
        drive(1, 0, 0, 0, "b7_drop", 5'b0, 5'b0, 0, 0);

        // Address 4 (non-split): its busy bit is ignored
        b_sbsy = 5'b01000;
        drive(1, 1, 1, 0, "b4_bit0", 5'b0, 5'b0, 0, 0);
        drive(1, 1, 1, 0, "b4_bit1", 5'b0, 5'b0, 0, 0);
        drive(1, 1, 1, 1, "b4_hold", 5'b01000, 5'b0, 1, 0);
        b_sbsy = 5'b00000;
        drive(1, 0, 0, 0, "b4_drop", 5'b0, 5'b0, 0, 0);

        // Address 3 (split-capable, not busy)
        drive(1, 1, 1, 1, "b3_bit0", 5'b0, 5'b0, 0, 0);
        drive(1, 1, 1, 1, "b3_bit1", 5'b0, 5'b0, 0, 0);
        drive(1, 1, 1, 0, "b3_hold", 5'b00100, 5'b00100, 1, 0);
        drive(1, 0, 0, 0, "b3_drop", 5'b0, 5'b0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/addr_decoder_n.md
ADDR_DECODER_N -- requirements
Module: addr_decoder_n

Interface
REQ-001 SHALL have parameter SEL_BITS, default 2: width of the serially shifted slave index.
REQ-002 SHALL have parameter N_SLAVES, default 3: slaves 1..N_SLAVES; index 0 means no slave; elaboration SHALL fail if N_SLAVES > 2**SEL_BITS-1 or SEL_BITS < 1.
REQ-003 SHALL have parameter SPLIT_MASK [N_SLAVES-1:0], default 'b001: bit i-1 set marks slave i as split-capable.
REQ-004 SHALL have port CLK  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port B_UTIL  in  1  bus utilised by the granted master.
REQ-007 SHALL have port A_ADD  in  1  address phase active.
REQ-008 SHALL have port B_BUS_OUT  in  1  serial bus bit, LSB first.
REQ-009 SHALL have port B_SBSY  in  N_SLAVES  per-slave split-busy.
REQ-010 SHALL have port AD_SEL  out  N_SLAVES  one-hot slave select; bit i-1 selects slave i.
REQ-011 SHALL have port SPL_SEL  out  N_SLAVES  split-capable slave addressed, independent of busy.
REQ-012 SHALL have port AD_VALID  out  1  decoded index held and valid.
REQ-013 SHALL have port AD_ERR  out  1  decoded index is 0 or > N_SLAVES.

Function
REQ-014 SHALL implement states IDLE, SHIFT, HOLD, plus registered index idx[SEL_BITS-1:0] and bit counter cnt.
REQ-015 IDLE: on B_UTIL&A_ADD SHALL write B_BUS_OUT into idx[0], clear the rest of idx, set cnt=1, go SHIFT (go HOLD directly if SEL_BITS==1).
REQ-016 SHIFT: on B_UTIL&A_ADD SHALL write B_BUS_OUT into idx[cnt], cnt+1; the edge sampling bit SEL_BITS-1 SHALL go HOLD.
REQ-017 SHIFT with B_UTIL=1, A_ADD=0 (abort) SHALL go IDLE with idx and cnt cleared; no output asserts.
REQ-018 HOLD SHALL persist while B_UTIL=1; A_ADD and B_BUS_OUT SHALL be ignored in HOLD.
REQ-019 B_UTIL=0 in any state SHALL go IDLE next edge with idx=0, cnt=0.
REQ-020 Latency: with bits on SEL_BITS consecutive sampled edges, AD_VALID SHALL be 1 in the cycle following the last sampling edge.
REQ-021 AD_VALID SHALL equal (state==HOLD), registered-state derived, no glitch on inputs.
REQ-022 AD_ERR SHALL be HOLD & (idx==0 | idx>N_SLAVES); AD_SEL and SPL_SEL SHALL be 0 when AD_ERR=1.
REQ-023 AD_SEL[i-1] SHALL be HOLD & idx==i & ~(SPLIT_MASK[i-1] & B_SBSY[i-1]); B_SBSY path combinational, same-cycle.
REQ-024 SPL_SEL[i-1] SHALL be HOLD & idx==i & SPLIT_MASK[i-1]; B_SBSY SHALL not affect SPL_SEL.
REQ-025 B_SBSY bits of non-split slaves SHALL be ignored.
REQ-026 AD_SEL and SPL_SEL SHALL each be one-hot or zero at all times.
REQ-027 Back-to-back transactions: B_UTIL low for one cycle SHALL suffice to return to IDLE and accept a new address on the next edge.

Reset
REQ-028 RST=1 at a rising edge SHALL force IDLE, idx=0, cnt=0, overriding all other inputs, including mid-SHIFT or HOLD.
REQ-029 After reset AD_SEL=0, SPL_SEL=0, AD_VALID=0, AD_ERR=0 until a complete address is shifted.

Verification (defaults unless stated)
REQ-030 Address 2, bits 0 then 1 with B_UTIL=A_ADD=1 -> next cycle AD_VALID=1, AD_SEL=3'b010, held while B_UTIL=1; B_UTIL=0 -> all outputs 0 next cycle.
REQ-031 Address 1 with B_SBSY=3'b001 -> AD_SEL=0, SPL_SEL=3'b001, AD_VALID=1; drop B_SBSY -> AD_SEL=3'b001 same cycle.
REQ-032 Address 0 -> AD_VALID=1, AD_ERR=1, AD_SEL=0, SPL_SEL=0.
REQ-033 Abort: one bit shifted then A_ADD=0, B_UTIL=1 -> AD_VALID stays 0; following full address 3 -> AD_SEL=3'b100.
REQ-034 RST=1 during HOLD on slave 3 -> next cycle all outputs 0; RST=1 for one edge mid-SHIFT -> partial bits discarded.
REQ-035 SEL_BITS=3, N_SLAVES=5, SPLIT_MASK=5'b10100: address 5 with B_SBSY=5'b10000 -> AD_SEL=0, SPL_SEL=5'b10000; address 7 -> AD_ERR=1.
